bit_to_time: RTL and testbench
==============================

# bit_to_time

Converts an eight-position digit frame in hh-mm-ss layout (one 4-bit code per display position) back into binary hour, minute and second values. It validates the digits and the time ranges, then runs a sequential reverse double-dabble (shift right, subtract 3) conversion on each two-digit field. It sits in the time-setting path, between the digit entry/edit logic and the time counter load port. It is the inverse of the binary-to-display-digit conversion feeding the display.

## Interface
Parameters:
- HOUR_MAX, 23: largest legal hour.
- MIN_MAX, 59: largest legal minute and second.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request; samples the digit frame.
- bit_7 … bit_0  in  4 each  digit codes, left to right. bit_7/6 are hour tens/units, bit_4/3 minute, bit_1/0 second. bit_5 and bit_2 are separators and are ignored.
- hour  out  6  converted hour.
- minute  out  6  converted minute.
- second  out  6  converted second.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  result of the last conversion: 1 means the frame was rejected.

Codes: 0–9 are digits, 10 is space, 11 is dash, 12–15 are illegal.

## Operation
- States: IDLE, CHECK, CONV, FIN.
- **IDLE:** start=1 captures all six digit codes and moves to CHECK. busy rises at that edge.
- **CHECK (1 cycle):** the frame is legal only if all of the following hold:
  - Each units code is 0–9.
  - Each tens code is 0–9 or 10; space in a tens position counts as 0.
  - hour ≤ HOUR_MAX, minute ≤ MIN_MAX, second ≤ MIN_MAX.
  - Legal → CONV with iteration counter 0. Illegal → FIN with the error flag set.
- **CONV:** each field uses its own 14-bit register {bcd[7:0], bin[5:0]}, loaded with {tens, units, 6'b0}. Each iteration takes two cycles:
  - Phase 0: shift the whole register right by 1.
  - Phase 1: in each bcd nibble, if nibble ≥ 8 then subtract 3.
  - After 6 iterations (12 cycles), bin[5:0] holds the result and bcd is 0. Go to FIN.
- **FIN (1 cycle):** register the outputs, pulse done, clear busy, return to IDLE.
  - Legal frame: hour, minute and second load the three bin fields; err=0.
  - Illegal frame: err=1; hour, minute and second keep their previous values.
- start while busy=1 is ignored; it is not queued.
- Digit inputs are don't-care except on the start cycle.

## Timing
- **Reset values:** hour=minute=second=0, busy=0, done=0, err=0, state IDLE. Internal shift registers and counters are cleared.
- **Reset mid-conversion:** abort. The next cycle shows reset values and no done pulse.
- **Latency, legal frame** (start sampled at edge N):
  - busy=1 after edge N.
  - CHECK occupies N+1; CONV occupies edges N+2 … N+13.
  - At edge N+14: outputs update, done=1 for one cycle, busy=0.
- **Latency, illegal frame:** outputs update at edge N+2 with done=1, err=1, busy=0.
- done and the new outputs are visible in the same cycle.
- A start asserted in the cycle where done=1 is accepted, since the state is IDLE by then; back-to-back throughput is one conversion per 15 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package / header:**
  - Digit code constants: DIG_SPACE=10, DIG_DASH=11.
  - State encodings.
  - CONV_ITER=6.
  - Field width 6 and BCD width 8.
- **Sub-module `bcd2_to_bin`:** one 14-bit conversion lane with load, shift-phase and correct-phase controls. It is instantiated three times (hour, minute, second) and driven by a single shared FSM and iteration counter in the top.
- Range and digit checks stay combinational in the top, registered into the CHECK decision.

## Test plan
- **Legal max:** frame 2,3,11,5,9,11,5,9 → hour=23, minute=59, second=59, err=0. done is seen exactly 14 cycles after start is sampled.
- **Hour out of range:** frame 2,4,11,0,0,11,0,0 → err=1, done 2 cycles after start. Outputs keep their prior values (e.g. still 23/59/59).
- **Blank tens and bad digit:** frame 10,5,11,0,7,11,10,9 → 5/7/9, err=0. Then the same frame with bit_0=12 → err=1, outputs unchanged.
- **Busy protection:** a second start 5 cycles after the first, with a different frame, is ignored. Exactly one done pulse; results come from the first frame only.
- **Reset mid-conversion:** assert rst for 1 cycle at cycle 8 of a conversion → all outputs 0 and busy=0 next cycle, no done. A fresh start then converts 12/34/56 correctly.
- **Exhaustive field sweep:** every legal hour 0–23 and minute/second 0–59 converts correctly, with bcd residue 0 at FIN (internal assertion).

Source files
------------

// File: rtl/bit_to_time_pkg.sv
// Shared constants, state encoding and small digit helpers for the
// digit-frame to binary time converter.
package bit_to_time_pkg;

   localparam logic [3:0] DIG_SPACE = 4'd10;
   localparam logic [3:0] DIG_DASH  = 4'd11;

   localparam int CONV_ITER = 6;
   localparam int FIELD_W   = 6;
   localparam int BCD_W     = 8;
   localparam int LANE_W    = BCD_W + FIELD_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CONV,
      ST_FIN
   } state_t;

   // A blank tens position reads as zero.
   function automatic logic [3:0] tens_value(input logic [3:0] code);
      return (code == DIG_SPACE) ? 4'd0 : code;
   endfunction

   function automatic logic [6:0] field_value(input logic [3:0] tens, input logic [3:0] units);
      return 7'(tens) * 7'd10 + 7'(units);
   endfunction

   function automatic logic [3:0] nibble_fix(input logic [3:0] nib);
      return (nib >= 4'd8) ? nib - 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// One reverse double-dabble lane: a two-digit BCD field shifted right into
// a 6-bit binary result, with a separate correction phase per iteration.
module bcd2_to_bin
   import bit_to_time_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic               correct,
   input  logic [3:0]         tens,
   input  logic [3:0]         units,
   output logic [FIELD_W-1:0] bin,
   output logic [BCD_W-1:0]   bcd
);

   logic [LANE_W-1:0] lane;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane <= '0;
      end else if (load) begin
         lane <= {tens, units, {FIELD_W{1'b0}}};
      end else if (shift) begin
         lane <= lane >> 1;
      end else if (correct) begin
         lane <= {nibble_fix(lane[LANE_W-1 -: 4]),
                  nibble_fix(lane[LANE_W-5 -: 4]),
                  lane[FIELD_W-1:0]};
      end
   end

   assign bin = lane[FIELD_W-1:0];
   assign bcd = lane[LANE_W-1:FIELD_W];

endmodule

// File: rtl/bit_to_time.sv
// Converts an hh-mm-ss digit frame into binary hour/minute/second, rejecting
// illegal codes and out-of-range fields before a shared 12-cycle conversion.
module bit_to_time
   import bit_to_time_pkg::*;
#(
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         bit_7,
   input  logic [3:0]         bit_6,
   input  logic [3:0]         bit_5,
   input  logic [3:0]         bit_4,
   input  logic [3:0]         bit_3,
   input  logic [3:0]         bit_2,
   input  logic [3:0]         bit_1,
   input  logic [3:0]         bit_0,
   output logic [FIELD_W-1:0] hour,
   output logic [FIELD_W-1:0] minute,
   output logic [FIELD_W-1:0] second,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [2:0] ITER_LAST = 3'(CONV_ITER - 1);

   state_t state, next_state;

   logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
   logic [2:0] iter;
   logic       phase;
   logic       err_flag;
   logic       frame_ok;
   logic       lane_load, lane_shift, lane_correct;

   logic [FIELD_W-1:0] h_bin, m_bin, s_bin;
   logic [BCD_W-1:0]   h_bcd, m_bcd, s_bcd;

   // Separator positions carry no information.
   logic unused_sep;
   assign unused_sep = ^{bit_5, bit_2};

   // NOTE: the shift lanes and counters sit in plain flops, so they are
   // cleared on reset like any other state; there is no RAM to skip.
   always_ff @(posedge clk) begin
      if (rst) begin
         {h_tens, h_units, m_tens, m_units, s_tens, s_units} <= '0;
      end else if (state == ST_IDLE && start) begin
         {h_tens, h_units, m_tens, m_units, s_tens, s_units} <=
            {bit_7, bit_6, bit_4, bit_3, bit_1, bit_0};
      end
   end

   // Tens accept 0-9 or blank (codes below dash); units accept 0-9 only.
   always_comb begin
      frame_ok = (h_tens < DIG_DASH) && (m_tens < DIG_DASH) && (s_tens < DIG_DASH) &&
                 (h_units < DIG_SPACE) && (m_units < DIG_SPACE) && (s_units < DIG_SPACE) &&
                 (field_value(tens_value(h_tens), h_units) <= 7'(HOUR_MAX)) &&
                 (field_value(tens_value(m_tens), m_units) <= 7'(MIN_MAX)) &&
                 (field_value(tens_value(s_tens), s_units) <= 7'(MIN_MAX));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_CHECK;
         ST_CHECK: next_state = frame_ok ? ST_CONV : ST_FIN;
         ST_CONV:  if (phase && iter == ITER_LAST) next_state = ST_FIN;
         ST_FIN:   next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      lane_load    = 1'b0;
      lane_shift   = 1'b0;
      lane_correct = 1'b0;
      case (state)
         ST_CHECK: lane_load = frame_ok;
         ST_CONV: begin
            lane_shift   = ~phase;
            lane_correct = phase;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iter     <= '0;
         phase    <= 1'b0;
         err_flag <= 1'b0;
      end else if (state == ST_CHECK) begin
         iter     <= '0;
         phase    <= 1'b0;
         err_flag <= ~frame_ok;
      end else if (state == ST_CONV) begin
         phase <= ~phase;
         if (phase) iter <= iter + 3'd1;
      end
   end

   bcd2_to_bin u_hour (
      .clk(clk), .rst(rst), .load(lane_load), .shift(lane_shift), .correct(lane_correct),
      .tens(tens_value(h_tens)), .units(h_units), .bin(h_bin), .bcd(h_bcd)
   );

   bcd2_to_bin u_minute (
      .clk(clk), .rst(rst), .load(lane_load), .shift(lane_shift), .correct(lane_correct),
      .tens(tens_value(m_tens)), .units(m_units), .bin(m_bin), .bcd(m_bcd)
   );

   bcd2_to_bin u_second (
      .clk(clk), .rst(rst), .load(lane_load), .shift(lane_shift), .correct(lane_correct),
      .tens(tens_value(s_tens)), .units(s_units), .bin(s_bin), .bcd(s_bcd)
   );

   // A rejected frame leaves the previous time on the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         hour   <= '0;
         minute <= '0;
         second <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         busy <= (next_state != ST_IDLE);
         done <= (state == ST_FIN);
         if (state == ST_FIN) begin
            err <= err_flag;
            if (!err_flag) begin
               hour   <= h_bin;
               minute <= m_bin;
               second <= s_bin;
            end
         end
      end
   end

   a_bcd_residue_zero: assert property (@(posedge clk) disable iff (rst)
      (state == ST_FIN && !err_flag) |-> (h_bcd == '0 && m_bcd == '0 && s_bcd == '0));

endmodule

// File: tb/tb_bit_to_time.sv
// Self-checking bench for bit_to_time: directed scenarios plus randomized
// frames compared against an arithmetic model of the frame rules.
module tb_bit_to_time;

   typedef logic [7:0][3:0] frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
   logic [5:0] hour, minute, second;
   logic       busy, done, err;

   int total = 0;
   int bad   = 0;

   logic [5:0] exp_h = '0, exp_m = '0, exp_s = '0;
   logic       exp_e = 1'b0;

   always #5 clk = ~clk;

   bit_to_time #(.HOUR_MAX(23), .MIN_MAX(59)) dut (
      .clk(clk), .rst(rst), .start(start),
      .bit_7(bit_7), .bit_6(bit_6), .bit_5(bit_5), .bit_4(bit_4),
      .bit_3(bit_3), .bit_2(bit_2), .bit_1(bit_1), .bit_0(bit_0),
      .hour(hour), .minute(minute), .second(second),
      .busy(busy), .done(done), .err(err)
   );

   // Reference model: decides legality and value straight from the frame rules.
   task automatic model_update(input frame_t f, output int exp_lat);
      int  ht, hu, mt, mu, st, su, hv, mv, sv;
      logic ok;
      ht = int'(f[7]); hu = int'(f[6]);
      mt = int'(f[4]); mu = int'(f[3]);
      st = int'(f[1]); su = int'(f[0]);
      ok = (ht <= 9 || ht == 10) && (mt <= 9 || mt == 10) && (st <= 9 || st == 10) &&
           hu <= 9 && mu <= 9 && su <= 9;
      hv = (ht == 10 ? 0 : ht) * 10 + hu;
      mv = (mt == 10 ? 0 : mt) * 10 + mu;
      sv = (st == 10 ? 0 : st) * 10 + su;
      if (ok && hv <= 23 && mv <= 59 && sv <= 59) begin
         exp_h = 6'(hv); exp_m = 6'(mv); exp_s = 6'(sv); exp_e = 1'b0;
         exp_lat = 14;
      end else begin
         exp_e = 1'b1;
         exp_lat = 2;
      end
   endtask

   function automatic frame_t make_frame(input int h, input int m, input int s);
      frame_t f;
      f[7] = (h / 10 == 0 && $urandom_range(0, 1) == 1) ? 4'd10 : 4'(h / 10);
      f[6] = 4'(h % 10);
      f[5] = 4'($urandom_range(0, 15));
      f[4] = (m / 10 == 0 && $urandom_range(0, 1) == 1) ? 4'd10 : 4'(m / 10);
      f[3] = 4'(m % 10);
      f[2] = 4'($urandom_range(0, 15));
      f[1] = (s / 10 == 0 && $urandom_range(0, 1) == 1) ? 4'd10 : 4'(s / 10);
      f[0] = 4'(s % 10);
      return f;
   endfunction

   task automatic drive_frame(input frame_t f);
      {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0} = f;
   endtask

   // Issues one start and waits (bounded) for done; lat counts edges after the start edge.
   task automatic run_conv(input frame_t f, output int lat);
      drive_frame(f);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drive_frame(frame_t'($urandom()));
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL conv_timeout: done=%b after %0d cycles, required 1", done, lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      drive_frame('0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if ({hour, minute, second} !== 18'd0) begin
         bad++;
         $display("FAIL reset_time: got %0d/%0d/%0d, required 0/0/0", hour, minute, second);
      end
      total++;
      if ({busy, done, err} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got busy=%b done=%b err=%b, required 000", busy, done, err);
      end
   endtask

   task automatic test_legal_max();
      frame_t f;
      int lat, el;
      f = {4'd2, 4'd3, 4'd11, 4'd5, 4'd9, 4'd11, 4'd5, 4'd9};
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if (lat != el) begin
         bad++;
         $display("FAIL legal_max_latency: got %0d, required %0d", lat, el);
      end
      total++;
      if ({hour, minute, second, err, busy} !== {exp_h, exp_m, exp_s, exp_e, 1'b0}) begin
         bad++;
         $display("FAIL legal_max_result: got %0d/%0d/%0d err=%b busy=%b, required %0d/%0d/%0d err=%b busy=0",
                  hour, minute, second, err, busy, exp_h, exp_m, exp_s, exp_e);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_width: got done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_hour_range();
      frame_t f;
      int lat, el;
      f = {4'd2, 4'd4, 4'd11, 4'd0, 4'd0, 4'd11, 4'd0, 4'd0};
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if (lat != el) begin
         bad++;
         $display("FAIL hour_range_latency: got %0d, required %0d", lat, el);
      end
      total++;
      if ({hour, minute, second, err, busy} !== {exp_h, exp_m, exp_s, exp_e, 1'b0}) begin
         bad++;
         $display("FAIL hour_range_result: got %0d/%0d/%0d err=%b busy=%b, required %0d/%0d/%0d err=%b busy=0",
                  hour, minute, second, err, busy, exp_h, exp_m, exp_s, exp_e);
      end
   endtask

   task automatic test_blank_and_bad_digit();
      frame_t f;
      int lat, el;
      f = {4'd10, 4'd5, 4'd11, 4'd0, 4'd7, 4'd11, 4'd10, 4'd9};
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
         bad++;
         $display("FAIL blank_tens: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                  hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
      end
      f[0] = 4'd12;
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
         bad++;
         $display("FAIL bad_digit: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                  hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
      end
   endtask

   task automatic test_busy_protection();
      frame_t fa, fb;
      int el, cyc, ndone, first;
      fa = make_frame(17, 42, 8);
      fb = make_frame(3, 15, 27);
      model_update(fa, el);
      drive_frame(fa);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_rise: got busy=%b after start edge, required 1", busy);
      end
      cyc = 0; ndone = 0; first = -1;
      while (cyc < 30) begin
         if (cyc == 4) begin
            drive_frame(fb);
            start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (done === 1'b1) begin
            ndone++;
            if (first < 0) first = cyc;
         end
      end
      total++;
      if (ndone != 1 || first != el) begin
         bad++;
         $display("FAIL busy_ignore: got %0d done pulses first at %0d, required 1 at %0d", ndone, first, el);
      end
      total++;
      if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e}) begin
         bad++;
         $display("FAIL busy_result: got %0d/%0d/%0d err=%b, required %0d/%0d/%0d err=%b",
                  hour, minute, second, err, exp_h, exp_m, exp_s, exp_e);
      end
   endtask

   task automatic test_reset_mid_conv();
      frame_t f;
      int el, lat, ndone;
      drive_frame(make_frame(9, 9, 9));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_h = '0; exp_m = '0; exp_s = '0; exp_e = 1'b0;
      total++;
      if ({hour, minute, second, busy, done, err} !== 21'd0) begin
         bad++;
         $display("FAIL mid_reset_values: got %0d/%0d/%0d busy=%b done=%b err=%b, required all 0",
                  hour, minute, second, busy, done, err);
      end
      ndone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL mid_reset_quiet: got %0d cycles with done/busy, required 0", ndone);
      end
      f = make_frame(12, 34, 56);
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
         bad++;
         $display("FAIL mid_reset_reconvert: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                  hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
      end
   endtask

   // Every hour, and every minute/second value (seconds as 59-minute).
   task automatic test_field_sweep();
      frame_t f;
      int el, lat;
      for (int i = 0; i < 84; i++) begin
         if (i < 24) f = make_frame(i, $urandom_range(0, 59), $urandom_range(0, 59));
         else        f = make_frame($urandom_range(0, 23), i - 24, 59 - (i - 24));
         model_update(f, el);
         run_conv(f, lat);
         total++;
         if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
            bad++;
            $display("FAIL sweep_%0d: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                     i, hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
         end
      end
   endtask

   task automatic test_random_frames();
      frame_t f;
      int el, lat;
      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < 8; p++) begin
            if ($urandom_range(0, 4) == 0) f[p] = 4'($urandom_range(0, 15));
            else if (p == 7 || p == 4 || p == 1) f[p] = 4'($urandom_range(0, 6));
            else f[p] = 4'($urandom_range(0, 9));
            if ((p == 7 || p == 4 || p == 1) && f[p] == 4'd6) f[p] = 4'd10;
         end
         model_update(f, el);
         run_conv(f, lat);
         total++;
         if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
            bad++;
            $display("FAIL random_%0d frame=%h: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                     i, f, hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
         end
      end
   endtask

   // Second start lands in the done cycle, giving one conversion per 15 cycles.
   task automatic test_back_to_back();
      frame_t f;
      int el, lat;
      f = make_frame(8, 30, 45);
      run_conv(f, lat);
      model_update(f, el);
      f = make_frame(21, 5, 50);
      model_update(f, el);
      run_conv(f, lat);
      total++;
      if ({hour, minute, second, err} !== {exp_h, exp_m, exp_s, exp_e} || lat != el) begin
         bad++;
         $display("FAIL back_to_back: got %0d/%0d/%0d err=%b lat=%0d, required %0d/%0d/%0d err=%b lat=%0d",
                  hour, minute, second, err, lat, exp_h, exp_m, exp_s, exp_e, el);
      end
   endtask

   initial begin
      test_reset();
      test_legal_max();
      test_hour_range();
      test_blank_and_bad_digit();
      test_busy_protection();
      test_reset_mid_conv();
      test_field_sweep();
      test_random_frames();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
